// File: rtl/mips_mem_arbiter.sv
// Instruction/data arbiter in front of a single-port memory with combinational read and posedge write.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin contention instead of fixed data priority.
module mips_mem_arbiter #(
    parameter logic [31:0] BOOT_BASE = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR = 32'h00000000,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic        instr_stall,
    output logic        instr_valid,
    output logic [31:0] instr_readdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_stall,
    output logic        data_valid,
    output logic [31:0] data_readdata,
    output logic        data_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        G_INSTR = 2'd1,
        G_DATA  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        halt_q;
    logic        store_q;
    logic [31:0] instr_readdata_q;
    logic [31:0] data_readdata_q;
    logic        err_q;

    logic        instr_halt;
    logic        instr_pend;
    logic        data_pend;

    // A fetch to the boot vector is always forwarded, even if it coincides with HALT_ADDR.
    assign instr_halt = reset_n && instr_req && (instr_address == HALT_ADDR) && (HALT_ADDR != BOOT_BASE);
    assign instr_pend = reset_n && instr_req && !instr_halt;
    assign data_pend  = reset_n && (data_read || data_write);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q;
`endif

    always_comb begin
        state_d = IDLE;
        if (instr_pend && data_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            state_d = last_data_q ? G_INSTR : G_DATA;
`else
            state_d = G_DATA;
`endif
        end else if (instr_pend) begin
            state_d = G_INSTR;
        end else if (data_pend) begin
            state_d = G_DATA;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        case (state_d)
            G_INSTR: begin
                mem_address = instr_address;
                mem_read    = 1'b1;
            end
            G_DATA: begin
                mem_address = data_address;
                if (data_write) begin
                    mem_write      = 1'b1;
                    mem_writedata  = data_writedata;
                    mem_byteenable = data_byteenable;
                end else begin
                    mem_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instr_stall = instr_pend && (state_d != G_INSTR);
    assign data_stall  = data_pend && (state_d != G_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            halt_q           <= 1'b0;
            store_q          <= 1'b0;
            instr_readdata_q <= '0;
            data_readdata_q  <= '0;
            err_q            <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= instr_halt;
            store_q <= data_write;
            if (state_d == G_INSTR) begin
                instr_readdata_q <= mem_readdata;
            end else if (instr_halt) begin
                instr_readdata_q <= NOP_WORD;
            end
            if (state_d == G_DATA && !data_write) begin
                data_readdata_q <= mem_readdata;
            end
            if (data_read && data_write) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to DATA so the first contention goes to the instruction port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data_q <= 1'b1;
        end else if (state_d == G_INSTR) begin
            last_data_q <= 1'b0;
        end else if (state_d == G_DATA) begin
            last_data_q <= 1'b1;
        end
    end
`endif

    assign instr_valid    = (state_q == G_INSTR) || halt_q;
    assign data_valid     = (state_q == G_DATA) && !store_q;
    assign instr_readdata = instr_readdata_q;
    assign data_readdata  = data_readdata_q;
    assign data_err       = err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: directed cases, randomized traffic, and mid-access reset.
module tb_mips_mem_arbiter;

    localparam logic [31:0] BOOT = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;
    localparam logic [31:0] NOP  = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_address = '0;
    logic        instr_stall, instr_valid;
    logic [31:0] instr_readdata;
    logic        data_read = 1'b0, data_write = 1'b0;
    logic [31:0] data_address = '0, data_writedata = '0;
    logic [3:0]  data_byteenable = '0;
    logic        data_stall, data_valid, data_err;
    logic [31:0] data_readdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byteenable;

    mips_mem_arbiter #(.BOOT_BASE(BOOT), .HALT_ADDR(HALT), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_address(instr_address), .instr_stall(instr_stall),
        .instr_valid(instr_valid), .instr_readdata(instr_readdata),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_writedata(data_writedata), .data_byteenable(data_byteenable),
        .data_stall(data_stall), .data_valid(data_valid), .data_readdata(data_readdata),
        .data_err(data_err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // RAM model: boot region maps to words 0..63, data region 0x100..0x3FC to words 64..255.
    logic [31:0] ram [256];
    assign mem_readdata = ram[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteenable[b]) ram[mem_address[9:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct { logic [31:0] data; int cycle; } exp_t;
    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] shadow [logic [31:0]];
    logic        lastd_m = 1'b1;
    logic        err_m = 1'b0;
    logic        st_i_m = 1'b0, st_d_m = 1'b0;
    logic [31:0] ilast = '0, dlast = '0;

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe);
        logic ih, ip, dp;
        int g;
        logic [31:0] w;
        @(negedge clk);
        chk("data_err", {31'b0, data_err}, {31'b0, err_m});
        instr_req = ir; instr_address = ia;
        data_read = dr; data_write = dw; data_address = da;
        data_writedata = dwd; data_byteenable = dbe;
        #2;
        ih = ir && (ia == HALT);
        ip = ir && !ih;
        dp = dr || dw;
        g = 0;
        if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = lastd_m ? 1 : 2;
`else
            g = 2;
`endif
        end else if (ip) g = 1;
        else if (dp) g = 2;
        st_i_m = ip && (g != 1);
        st_d_m = dp && (g != 2);
        chk("instr_stall", {31'b0, instr_stall}, {31'b0, st_i_m});
        chk("data_stall", {31'b0, data_stall}, {31'b0, st_d_m});
        chk("mem_read", {31'b0, mem_read}, {31'b0, (g == 1) || (g == 2 && !dw)});
        chk("mem_write", {31'b0, mem_write}, {31'b0, (g == 2 && dw)});
        chk("mem_address", mem_address, (g == 1) ? ia : (g == 2) ? da : 32'h0);
        if (g == 0) chk("mem_byteenable_idle", {28'b0, mem_byteenable}, 32'h0);
        if (ih) iq.push_back('{NOP, cyc + 1});
        if (g == 1) iq.push_back('{shadow[ia], cyc + 1});
        if (g == 2 && !dw) dq.push_back('{shadow[da], cyc + 1});
        if (g == 2 && dw) begin
            chk("mem_writedata", mem_writedata, dwd);
            chk("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, dbe});
            w = shadow[da];
            for (int b = 0; b < 4; b++) if (dbe[b]) w[8*b +: 8] = dwd[8*b +: 8];
            shadow[da] = w;
        end
        if (g == 1) lastd_m = 1'b0;
        if (g == 2) lastd_m = 1'b1;
        if (dr && dw) err_m = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a valid pulse is due or seen.
    always @(negedge clk) begin
        if (reset_n) begin
            logic ev;
            exp_t e;
            ev = (iq.size() > 0) && (iq[0].cycle == cyc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
            if (ev) begin
                e = iq.pop_front();
                ilast = e.data;
            end
            chk("instr_readdata", instr_readdata, ilast);
            ev = (dq.size() > 0) && (dq[0].cycle == cyc);
            chk("data_valid", {31'b0, data_valid}, {31'b0, ev});
            if (ev) begin
                e = dq.pop_front();
                dlast = e.data;
            end
            chk("data_readdata", data_readdata, dlast);
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_data_valid"}, {31'b0, data_valid}, 32'h0);
        chk({tag, "_instr_stall"}, {31'b0, instr_stall}, 32'h0);
        chk({tag, "_data_stall"}, {31'b0, data_stall}, 32'h0);
        chk({tag, "_instr_readdata"}, instr_readdata, 32'h0);
        chk({tag, "_data_readdata"}, data_readdata, 32'h0);
        chk({tag, "_data_err"}, {31'b0, data_err}, 32'h0);
        chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'h0);
    endtask

    task automatic model_reset();
        iq.delete(); dq.delete();
        lastd_m = 1'b1; err_m = 1'b0; st_i_m = 1'b0; st_d_m = 1'b0;
        ilast = '0; dlast = '0;
    endtask

    logic        r_ir, r_dr, r_dw;
    logic [31:0] r_ia, r_da, r_wd;
    logic [3:0]  r_be;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            if (i < 64) shadow[BOOT + 32'(4 * i)] = ram[i];
            else        shadow[32'(4 * i)] = ram[i];
        end
        ram[0] = 32'h8C020000;
        shadow[BOOT] = 32'h8C020000;

        repeat (2) @(negedge clk);
        reset_checks("por");
        #1 reset_n = 1'b1;

        step(1'b1, BOOT, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b1, HALT, 1'b1, 1'b0, 32'h100, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step(1'b1, BOOT + 32'h4, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'hF);
        step(1'b0, '0, 1'b0, 1'b1, 32'h204, 32'hDEADBEEF, 4'hF);
        step(1'b0, '0, 1'b1, 1'b0, 32'h204, '0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h208, 32'hA5A5_0F0F, 4'b0101);
        step(1'b0, '0, 1'b1, 1'b0, 32'h208, '0, '0);
        step(1'b0, '0, 1'b1, 1'b1, 32'h20C, 32'hCAFEF00D, 4'hF);
        step(1'b0, '0, 1'b1, 1'b0, 32'h20C, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        r_ir = 0; r_dr = 0; r_dw = 0; r_ia = '0; r_da = '0; r_wd = '0; r_be = '0;
        for (int n = 0; n < 400; n++) begin
            if (!st_i_m) begin
                r_ir = ($urandom_range(0, 2) != 0);
                r_ia = ($urandom_range(0, 3) == 0) ? HALT : BOOT + 32'(4 * $urandom_range(0, 63));
            end
            if (!st_d_m) begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3, 4, 5: begin r_dr = 1; r_dw = 0; end
                    6, 7, 8, 9:       begin r_dr = 0; r_dw = 1; end
                    10:               begin r_dr = 1; r_dw = 1; end
                    default:          begin r_dr = 0; r_dw = 0; end
                endcase
                r_da = 32'(4 * $urandom_range(64, 255));
                r_wd = $urandom;
                r_be = 4'($urandom_range(0, 15));
            end
            step(r_ir, r_ia, r_dr, r_dw, r_da, r_wd, r_be);
        end
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        // Reset asserted mid-cycle while a fetch and a store are being granted.
        @(negedge clk);
        instr_req = 1'b1; instr_address = BOOT + 32'h8;
        data_read = 1'b0; data_write = 1'b1; data_address = 32'h300;
        data_writedata = ~shadow[32'h300]; data_byteenable = 4'hF;
        #2 reset_n = 1'b0;
        #1 reset_checks("rst_mid");
        @(posedge clk);
        #1 chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_no_store", ram[192], shadow[32'h300]);
        reset_checks("rst_hold");
        @(negedge clk);
        instr_req = 1'b0; data_write = 1'b0;
        model_reset();
        #1 reset_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 32'h300, '0, '0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        chk("instr_queue_drained", iq.size(), 32'h0);
        chk("data_queue_drained", dq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
